// File: rtl/tlul_pkg.sv
// Shared TL-UL channel types and constants used by the bus blocks.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    // Widest requester index a host arbiter may fold into a_source.
    localparam int TL_HOST_IDX_W_MAX = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Host arbiter A-channel state.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector with an optional lock override.
// Searches upward from ptr (wrapping) for the first asserted request;
// while lock is high the locked index wins regardless of the others.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          lock,
    input  logic [IW-1:0] lock_idx,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Rotating priority search, or pass-through of the locked requester.
    always_comb begin
        int idx;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        if (lock) begin
            gnt_idx = lock_idx;
            for (int k = 0; k < N; k++) begin
                if (lock_idx == IW'(k)) begin
                    gnt_valid = req[k];
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!gnt_valid && req[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/tlul_host_arbiter.sv
// Merges NumHosts TL-UL requesters onto one host port. A channel is
// round-robin arbitrated and held locked until the device accepts; the
// requester index rides in the top a_source bits so responses can be
// steered back. In-flight requests are bounded per requester.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ARB_IDLE   | free to pick any eligible requester this cycle
//  ARB_LOCKED | a request is on the bus but not yet accepted; hold it
module tlul_host_arbiter
    import tlul_pkg::*;
#(
    parameter int NumHosts       = 2,
    parameter int MaxOutstanding = 2
) (
    input  logic    clock,
    input  logic    reset,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i
);

    localparam int IdxW = $clog2(NumHosts);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [CntW-1:0] cnt_q [NumHosts];
    logic [CntW-1:0] cnt_d [NumHosts];

    logic [NumHosts-1:0] elig;
    logic [IdxW-1:0]     gnt_idx;
    logic                gnt_valid;
    logic                a_hs;
    tl_h2d_t             a_sel;

    logic [IdxW-1:0]     rsp_idx;
    logic                rsp_ok;
    logic                d_ready_int;
    logic [NumHosts-1:0] d_hs;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        if (idx == IdxW'(NumHosts - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // A requester competes only while it has room for another in-flight request.
    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            elig[i] = tl_h_i[i].a_valid && (cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    rr_arbiter #(
        .N (NumHosts)
    ) u_rr (
        .req       (elig),
        .ptr       (ptr_q),
        .lock      (state_q == ARB_LOCKED),
        .lock_idx  (lock_idx_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Reset holds the bus quiet even if requesters are still driving.
    assign a_hs = gnt_valid && tl_d_i.a_ready && !reset;

    // Response steering from the index tag; out-of-range tags are sunk.
    always_comb begin
        rsp_idx     = tl_d_i.d_source[TL_AIW-1 -: IdxW];
        rsp_ok      = 1'b0;
        d_ready_int = 1'b1;
        d_hs        = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (rsp_idx == IdxW'(i)) begin
                rsp_ok = 1'b1;
                if (!reset) begin
                    d_ready_int = tl_h_i[i].d_ready;
                    d_hs[i]     = tl_d_i.d_valid && tl_h_i[i].d_ready;
                end
            end
        end
    end

    // Forward the granted requester's A channel with its index tagged in.
    always_comb begin
        a_sel = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (gnt_idx == IdxW'(i)) begin
                a_sel = tl_h_i[i];
            end
        end
        tl_d_o          = a_sel;
        tl_d_o.a_valid  = gnt_valid && !reset;
        tl_d_o.a_source = {gnt_idx, a_sel.a_source[TL_AIW-IdxW-1:0]};
        tl_d_o.d_ready  = d_ready_int;
    end

    // Per-requester D channel copy plus its A-channel ready.
    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i]                             = tl_d_i;
            tl_h_o[i].d_source[TL_AIW-1 -: IdxW]  = '0;
            tl_h_o[i].d_valid = tl_d_i.d_valid && rsp_ok && (rsp_idx == IdxW'(i)) && !reset;
            tl_h_o[i].a_ready = tl_d_i.a_ready && gnt_valid && (gnt_idx == IdxW'(i)) && !reset;
        end
    end

    // Next-state: advance the pointer past whoever just completed, or lock.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    if (tl_d_i.a_ready) begin
                        ptr_d = next_idx(gnt_idx);
                    end else begin
                        lock_idx_d = gnt_idx;
                        state_d    = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (tl_d_i.a_ready) begin
                    ptr_d   = next_idx(lock_idx_q);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outstanding counters; a response on an empty count is ignored.
    always_comb begin
        for (int i = 0; i < NumHosts; i++) begin
            logic inc;
            logic dec;
            inc      = a_hs && (gnt_idx == IdxW'(i));
            dec      = d_hs[i] && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            for (int i = 0; i < NumHosts; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
            for (int i = 0; i < NumHosts; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Protocol checks: reserved source bits, stray response tags, and
    // responses for requesters with nothing in flight.
    for (genvar g = 0; g < NumHosts; g++) begin : gen_sva
        a_src_idx_zero: assert property (@(posedge clock) disable iff (reset)
            tl_h_i[g].a_valid |-> (tl_h_i[g].a_source[TL_AIW-1 -: IdxW] == '0))
            else $error("requester %0d drove nonzero a_source index bits", g);

        d_rsp_has_req: assert property (@(posedge clock) disable iff (reset)
            d_hs[g] |-> (cnt_q[g] != '0))
            else $error("response for requester %0d with nothing outstanding", g);
    end

    d_rsp_idx_range: assert property (@(posedge clock) disable iff (reset)
        tl_d_i.d_valid |-> rsp_ok)
        else $error("response tagged with out-of-range requester index");

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Bench for tlul_host_arbiter (2 requesters, 2 outstanding): a directed
// vector table, hand sequences for lock hold and reset during lock, then
// random traffic checked against a transaction-level model.
module tb_tlul_host_arbiter;
    import tlul_pkg::*;

    localparam int NH = 2;
    localparam int MO = 2;

    logic    clock = 1'b0;
    logic    reset;
    tl_h2d_t tl_h_i [NH];
    tl_d2h_t tl_h_o [NH];
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    tlul_host_arbiter #(
        .NumHosts       (NH),
        .MaxOutstanding (MO)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i)
    );

    typedef struct packed {
        logic [1:0]  hv;
        logic        ar;
        logic        dv;
        logic [7:0]  dsrc;
        logic [1:0]  hdr;
        logic        exp_av;
        logic [7:0]  exp_src;
        logic [31:0] exp_addr;
        logic [1:0]  exp_ar;
        logic [1:0]  exp_dv;
        logic        exp_dr;
    } vec_t;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;

    vec_t tv [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_host(input int i, input logic v, input logic [7:0] src,
                              input logic [31:0] addr, input logic dr);
        tl_h_i[i].a_valid   = v;
        tl_h_i[i].a_opcode  = Get;
        tl_h_i[i].a_param   = 3'h0;
        tl_h_i[i].a_size    = 2'h2;
        tl_h_i[i].a_source  = src;
        tl_h_i[i].a_address = addr;
        tl_h_i[i].a_mask    = 4'hf;
        tl_h_i[i].a_data    = 32'h0;
        tl_h_i[i].d_ready   = dr;
    endtask

    task automatic drive_dev(input logic ar, input logic dv, input logic [7:0] dsrc);
        tl_d_i.a_ready  = ar;
        tl_d_i.d_valid  = dv;
        tl_d_i.d_opcode = AccessAckData;
        tl_d_i.d_param  = 3'h0;
        tl_d_i.d_size   = 2'h2;
        tl_d_i.d_source = dsrc;
        tl_d_i.d_sink   = 1'b0;
        tl_d_i.d_data   = {24'hA5A5A5, dsrc};
        tl_d_i.d_error  = 1'b0;
    endtask

    // Fixed-payload stimulus used by the table and hand sequences.
    task automatic apply(input logic [1:0] hv, input logic ar, input logic dv,
                         input logic [7:0] dsrc, input logic [1:0] hdr);
        drive_host(0, hv[0], 8'h03, A0, hdr[0]);
        drive_host(1, hv[1], 8'h05, A1, hdr[1]);
        drive_dev(ar, dv, dsrc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(2'b00, 1'b0, 1'b0, 8'h00, 2'b11);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Transaction-level reference for the random phase.
    int          m_ptr;
    bit          m_locked;
    int          m_lidx;
    int          m_cnt [NH];
    logic [7:0]  m_dq [$];
    bit          h_req [NH];
    logic [7:0]  h_src [NH];
    logic [31:0] h_addr [NH];
    bit          dv_held;

    initial begin
        reset = 1'b1;
        apply(2'b11, 1'b1, 1'b1, 8'h03, 2'b00);

        // Reset values, with inputs actively driving.
        @(negedge clock);
        #1;
        chk("rst a_valid", tl_d_o.a_valid, 1'b0);
        chk("rst d_ready", tl_d_o.d_ready, 1'b1);
        chk("rst a_ready", {tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 2'b00);
        chk("rst d_valid", {tl_h_o[1].d_valid, tl_h_o[0].d_valid}, 2'b00);
        apply(2'b00, 1'b0, 1'b0, 8'h00, 2'b11);
        @(negedge clock);
        reset = 1'b0;

        //            hv     ar    dv    dsrc   hdr    av    src    addr  a_rdy  d_vld  d_rdy
        tv[0]  = '{2'b00, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00, 1'b1};
        tv[1]  = '{2'b01, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h03, A0,    2'b01, 2'b00, 1'b1};
        tv[2]  = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h85, A1,    2'b10, 2'b00, 1'b1};
        tv[3]  = '{2'b11, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 8'h03, A0,    2'b00, 2'b00, 1'b1};
        tv[4]  = '{2'b11, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 8'h03, A0,    2'b00, 2'b00, 1'b1};
        tv[5]  = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h03, A0,    2'b01, 2'b00, 1'b1};
        tv[6]  = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h85, A1,    2'b10, 2'b00, 1'b1};
        tv[7]  = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00, 1'b1};
        tv[8]  = '{2'b11, 1'b1, 1'b1, 8'h03, 2'b11, 1'b0, 8'h00, 32'h0, 2'b00, 2'b01, 1'b1};
        tv[9]  = '{2'b11, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h03, A0,    2'b01, 2'b00, 1'b1};
        tv[10] = '{2'b10, 1'b1, 1'b1, 8'h85, 2'b01, 1'b0, 8'h00, 32'h0, 2'b00, 2'b10, 1'b0};
        tv[11] = '{2'b10, 1'b1, 1'b1, 8'h85, 2'b11, 1'b0, 8'h00, 32'h0, 2'b00, 2'b10, 1'b1};
        tv[12] = '{2'b10, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h85, A1,    2'b10, 2'b00, 1'b1};
        tv[13] = '{2'b01, 1'b1, 1'b1, 8'h03, 2'b11, 1'b0, 8'h00, 32'h0, 2'b00, 2'b01, 1'b1};
        tv[14] = '{2'b01, 1'b1, 1'b1, 8'h03, 2'b01, 1'b1, 8'h03, A0,    2'b01, 2'b01, 1'b1};
        tv[15] = '{2'b01, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 8'h03, A0,    2'b01, 2'b00, 1'b1};
        tv[16] = '{2'b01, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 8'h00, 32'h0, 2'b00, 2'b00, 1'b1};

        for (int n = 0; n < 17; n++) begin
            @(negedge clock);
            apply(tv[n].hv, tv[n].ar, tv[n].dv, tv[n].dsrc, tv[n].hdr);
            #1;
            chk($sformatf("tbl%0d a_valid", n), tl_d_o.a_valid, tv[n].exp_av);
            if (tv[n].exp_av) begin
                chk($sformatf("tbl%0d a_source", n), tl_d_o.a_source, tv[n].exp_src);
                chk($sformatf("tbl%0d a_address", n), tl_d_o.a_address, tv[n].exp_addr);
            end
            chk($sformatf("tbl%0d a_ready", n), {tl_h_o[1].a_ready, tl_h_o[0].a_ready}, tv[n].exp_ar);
            chk($sformatf("tbl%0d d_valid", n), {tl_h_o[1].d_valid, tl_h_o[0].d_valid}, tv[n].exp_dv);
            chk($sformatf("tbl%0d d_ready", n), tl_d_o.d_ready, tv[n].exp_dr);
            if (tv[n].dv) begin
                chk($sformatf("tbl%0d d_source", n), tl_h_o[int'(tv[n].dsrc[7])].d_source,
                    {1'b0, tv[n].dsrc[6:0]});
            end
        end

        // Lock hold: host1 stalled 3 cycles while host0 joins.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            apply((c == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 8'h00, 2'b11);
            #1;
            chk($sformatf("lock%0d a_valid", c), tl_d_o.a_valid, 1'b1);
            chk($sformatf("lock%0d a_source", c), tl_d_o.a_source, 8'h85);
            chk($sformatf("lock%0d a_address", c), tl_d_o.a_address, A1);
        end
        @(negedge clock);
        apply(2'b11, 1'b1, 1'b0, 8'h00, 2'b11);
        #1;
        chk("lock release a_ready", {tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 2'b10);
        @(negedge clock);
        apply(2'b11, 1'b1, 1'b0, 8'h00, 2'b11);
        #1;
        chk("lock next a_source", tl_d_o.a_source, 8'h03);
        chk("lock next a_ready", {tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 2'b01);

        // Reset while locked: pointer, lock and counters must clear.
        do_reset();
        @(negedge clock);
        apply(2'b01, 1'b1, 1'b0, 8'h00, 2'b11);
        @(negedge clock);
        apply(2'b10, 1'b0, 1'b0, 8'h00, 2'b11);
        #1;
        chk("rl locked a_source", tl_d_o.a_source, 8'h85);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rl in-reset a_valid", tl_d_o.a_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        apply(2'b00, 1'b1, 1'b0, 8'h00, 2'b11);
        #1;
        chk("rl post a_valid", tl_d_o.a_valid, 1'b0);
        @(negedge clock);
        apply(2'b11, 1'b1, 1'b0, 8'h00, 2'b11);
        #1;
        chk("rl ptr a_source", tl_d_o.a_source, 8'h03);
        @(negedge clock);
        apply(2'b01, 1'b1, 1'b0, 8'h00, 2'b11);
        #1;
        chk("rl cnt a_ready", {tl_h_o[1].a_ready, tl_h_o[0].a_ready}, 2'b01);
        @(negedge clock);
        apply(2'b01, 1'b1, 1'b0, 8'h00, 2'b11);
        #1;
        chk("rl limit a_valid", tl_d_o.a_valid, 1'b0);

        // Random traffic against the transaction model.
        do_reset();
        m_ptr = 0; m_locked = 0; m_lidx = 0; dv_held = 0;
        m_dq.delete();
        for (int i = 0; i < NH; i++) begin
            m_cnt[i] = 0; h_req[i] = 0; h_src[i] = '0; h_addr[i] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [1:0] hdr;
            logic       ar;
            logic       dv;
            int         g;
            bit         gv;
            int         r;
            @(negedge clock);
            for (int i = 0; i < NH; i++) begin
                if (!h_req[i] && ($urandom_range(0, 2) != 0)) begin
                    h_req[i]  = 1;
                    h_src[i]  = 8'($urandom_range(0, 127));
                    h_addr[i] = $urandom & 32'hFFFF_FFFC;
                end
            end
            hdr = 2'($urandom_range(0, 3));
            ar  = ($urandom_range(0, 3) != 0);
            dv  = dv_held || ((m_dq.size() > 0) && ($urandom_range(0, 1) == 1));
            for (int i = 0; i < NH; i++) begin
                drive_host(i, h_req[i], h_src[i], h_addr[i], hdr[i]);
            end
            drive_dev(ar, dv, dv ? m_dq[0] : 8'h00);
            #1;

            g  = 0;
            gv = 0;
            if (m_locked) begin
                g  = m_lidx;
                gv = h_req[g] && (m_cnt[g] < MO);
            end else begin
                for (int k = 0; k < NH; k++) begin
                    int h;
                    h = (m_ptr + k) % NH;
                    if (!gv && h_req[h] && (m_cnt[h] < MO)) begin
                        gv = 1;
                        g  = h;
                    end
                end
            end
            chk("rnd a_valid", tl_d_o.a_valid, gv);
            if (gv) begin
                chk("rnd a_source", tl_d_o.a_source, {1'(g), h_src[g][6:0]});
                chk("rnd a_address", tl_d_o.a_address, h_addr[g]);
            end
            for (int i = 0; i < NH; i++) begin
                chk($sformatf("rnd a_ready%0d", i), tl_h_o[i].a_ready, gv && (g == i) && ar);
            end
            r = dv ? int'(m_dq[0][7]) : 0;
            for (int i = 0; i < NH; i++) begin
                chk($sformatf("rnd d_valid%0d", i), tl_h_o[i].d_valid, dv && (r == i));
            end
            if (dv) begin
                chk("rnd d_ready", tl_d_o.d_ready, hdr[r]);
                chk("rnd d_source", tl_h_o[r].d_source, {1'b0, m_dq[0][6:0]});
            end else begin
                chk("rnd idle d_ready", tl_d_o.d_ready, hdr[0]);
            end

            if (gv && ar) begin
                m_cnt[g]++;
                m_dq.push_back({1'(g), h_src[g][6:0]});
                h_req[g] = 0;
                m_ptr    = (g + 1) % NH;
                m_locked = 0;
            end else if (gv && !m_locked) begin
                m_locked = 1;
                m_lidx   = g;
            end else if (m_locked && ar) begin
                m_ptr    = (m_lidx + 1) % NH;
                m_locked = 0;
            end
            if (dv && hdr[r]) begin
                m_cnt[r]--;
                void'(m_dq.pop_front());
                dv_held = 0;
            end else begin
                dv_held = dv;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
